// File: rtl/cache_element_streamer.sv
// Streams requested elements from a block-organised cache SRAM to a PE over valid/ready.
// Define CACHE_STREAM_PREFETCH_EN to prefetch the next block and hide block-crossing bubbles.
module cache_element_streamer #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_ELEMENTS        = 2,
  parameter int DEPTH              = 64,
  parameter int LG_DEPTH           = 6,
  parameter int WIDTH              = 128
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [LG_DEPTH+LG_ELEMENTS-1:0] req_addr,
  input  logic [15:0]                     req_count,
  output logic                            ram_en,
  output logic [LG_DEPTH-1:0]             ram_addr,
  input  logic [WIDTH-1:0]                ram_dout,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ELEMENT_WIDTH-1:0]        out_data,
  output logic                            out_last,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STREAM} state_t;

  localparam logic [LG_ELEMENTS-1:0] OFF_MAX = LG_ELEMENTS'(ELEMENTS_PER_BLOCK - 1);
  localparam logic [LG_DEPTH-1:0]    BLK_MAX = LG_DEPTH'(DEPTH - 1);

  state_t                  state, state_nx;
  logic [LG_DEPTH-1:0]     blk;
  logic [LG_ELEMENTS-1:0]  off;
  logic [15:0]             rem;
  logic [WIDTH-1:0]        block;
  logic                    accept, hs, last_beat, blk_end;

`ifdef CACHE_STREAM_PREFETCH_EN
  logic [WIDTH-1:0]        nxt_block;
  logic                    nxt_vld, first, cap, hold, pf_issue;
`endif

  function automatic logic [LG_DEPTH-1:0] blk_inc(input logic [LG_DEPTH-1:0] b);
    return (b == BLK_MAX) ? '0 : b + 1'b1;
  endfunction

  function automatic logic [ELEMENT_WIDTH-1:0] elem(input logic [WIDTH-1:0] w,
                                                    input logic [LG_ELEMENTS-1:0] i);
    return w[int'(i)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept && req_count != 16'd0) state_nx = FETCH;
      FETCH:  state_nx = LOAD;
      LOAD:   state_nx = STREAM;
      STREAM: begin
        if (hs && last_beat) state_nx = IDLE;
`ifndef CACHE_STREAM_PREFETCH_EN
        else if (hs && blk_end) state_nx = FETCH;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    accept    = req_valid & req_ready;
`ifdef CACHE_STREAM_PREFETCH_EN
    out_valid = (state == STREAM) & ~hold;
    // Fetch the following block only when the request runs past this one.
    pf_issue  = (state == STREAM) & first &
                ({1'b0, rem} > (17'(ELEMENTS_PER_BLOCK) - 17'(off)));
    ram_en    = (state == FETCH) | pf_issue;
    ram_addr  = pf_issue ? blk_inc(blk) : blk;
`else
    out_valid = (state == STREAM);
    ram_en    = (state == FETCH);
    ram_addr  = blk;
`endif
    hs        = out_valid & out_ready;
    last_beat = (rem == 16'd1);
    blk_end   = (off == OFF_MAX);
    out_last  = out_valid & last_beat;
    out_data  = out_valid ? elem(block, off) : '0;
  end

  // Control state: element counter and prefetch bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
`ifdef CACHE_STREAM_PREFETCH_EN
      nxt_vld <= 1'b0;
      first   <= 1'b0;
      cap     <= 1'b0;
      hold    <= 1'b0;
`endif
    end else begin
      if (accept)  rem <= req_count;
      else if (hs) rem <= rem - 1'b1;
`ifdef CACHE_STREAM_PREFETCH_EN
      cap   <= pf_issue;
      first <= (state == LOAD);
      if (hs && last_beat) begin
        nxt_vld <= 1'b0;
        hold    <= 1'b0;
        cap     <= 1'b0;
      end else if (hs && blk_end) begin
        // Swap in the next block now if it has arrived, else stall until it does.
        if (nxt_vld || cap) begin
          nxt_vld <= 1'b0;
          first   <= 1'b1;
        end else begin
          hold <= 1'b1;
        end
      end else if (cap) begin
        if (hold) begin
          hold  <= 1'b0;
          first <= 1'b1;
        end else begin
          nxt_vld <= 1'b1;
        end
      end
`endif
    end
  end

  // Datapath: block/offset pointers and block storage
  always_ff @(posedge clock) begin
    if (accept) begin
      blk <= req_addr[LG_DEPTH+LG_ELEMENTS-1:LG_ELEMENTS];
      off <= req_addr[LG_ELEMENTS-1:0];
    end else if (hs) begin
      off <= off + 1'b1;
      if (blk_end) blk <= blk_inc(blk);
    end
    if (state == LOAD) block <= ram_dout;
`ifdef CACHE_STREAM_PREFETCH_EN
    if (hs && blk_end && !last_beat) begin
      if (nxt_vld)  block <= nxt_block;
      else if (cap) block <= ram_dout;
    end else if (cap && hold) begin
      block <= ram_dout;
    end
    if (cap) nxt_block <= ram_dout;
`endif
  end

endmodule

// File: tb/tb_cache_element_streamer.sv
// Directed bench for cache_element_streamer: SRAM model, expected-beat queue and
// per-cycle compare, plus literal expectations for the documented scenarios.
module tb_cache_element_streamer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_addr = '0;
  logic [15:0]  req_count = '0;
  logic         ram_en;
  logic [5:0]   ram_addr;
  logic [127:0] ram_dout = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  cache_element_streamer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_count(req_count), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic [127:0] mem [0:63];
  beat_t        exp_q[$];
  int           hs_cyc[$];
  logic [31:0]  hs_data[$];
  int           ram_log[$];
  int           cyc = 0;
  int           acc_cyc = 0;
  int           checks = 0;
  int           errors = 0;

  // Element value at block b, offset o; block 3 holds 0x00,0x11,0x22,0x33.
  function automatic logic [31:0] mval(input int b, input int o);
    if (b == 3) return 32'(o * 17);
    return 32'hA000_0000 | 32'(b << 8) | 32'(o);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (ram_en) ram_log.push_back(int'(ram_addr));
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(out_valid), 32'd0);
        else begin
          check("beat_data", out_data, exp_q[0].d);
          check("beat_last", 32'(out_last), 32'(exp_q[0].l));
          if (out_ready) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(out_data);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("last_without_valid", 32'(out_last), 32'd0);
      end
    end
  end

  task automatic run_req(input logic [7:0] a, input logic [15:0] n, input bit toggle);
    int guard;
    beat_t bt;
    hs_data.delete();
    hs_cyc.delete();
    ram_log.delete();
    for (int i = 0; i < int'(n); i++) begin
      int e;
      e = (int'(a) + i) % 256;
      bt.d = mval(e / 4, e % 4);
      bt.l = (i == int'(n) - 1);
      exp_q.push_back(bt);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_count = n;
    check("req_ready_at_send", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clock); #1;
      guard++;
    end
    out_ready = 1'b1;
    check("done_in_budget", 32'(guard < 300), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int b = 0; b < 64; b++)
      mem[b] = {mval(b, 3), mval(b, 2), mval(b, 1), mval(b, 0)};

    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Two beats inside block 3
    run_req(8'd13, 16'd2, 1'b0);
    check("t1_beats", 32'(hs_data.size()), 32'd2);
    if (hs_data.size() == 2) begin
      check("t1_b0", hs_data[0], 32'h11);
      check("t1_b1", hs_data[1], 32'h22);
      check("t1_latency", 32'(hs_cyc[0] - acc_cyc), 32'd3);
    end
    check("t1_ram_reads", 32'(ram_log.size()), 32'd1);

    // Crossing from block 3 into block 4
    run_req(8'd14, 16'd4, 1'b0);
    check("t2_beats", 32'(hs_data.size()), 32'd4);
    if (hs_data.size() == 4) begin
      check("t2_b0", hs_data[0], 32'h22);
      check("t2_b1", hs_data[1], 32'h33);
      check("t2_b2", hs_data[2], 32'hA000_0400);
      check("t2_b3", hs_data[3], 32'hA000_0401);
`ifdef CACHE_STREAM_PREFETCH_EN
      check("t2_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
`else
      check("t2_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
`endif
    end
    if (ram_log.size() == 2) begin
      check("t2_ram0", 32'(ram_log[0]), 32'd3);
      check("t2_ram1", 32'(ram_log[1]), 32'd4);
    end else check("t2_ram_reads", 32'(ram_log.size()), 32'd2);

    // Wrap from the last element of block 63 to block 0
    run_req(8'd255, 16'd2, 1'b0);
    check("t3_beats", 32'(hs_data.size()), 32'd2);
    if (hs_data.size() == 2) begin
      check("t3_b0", hs_data[0], 32'hA000_3F03);
      check("t3_b1", hs_data[1], 32'hA000_0000);
    end
    if (ram_log.size() == 2) begin
      check("t3_ram0", 32'(ram_log[0]), 32'd63);
      check("t3_ram1", 32'(ram_log[1]), 32'd0);
    end else check("t3_ram_reads", 32'(ram_log.size()), 32'd2);

    // Zero-length request
    run_req(8'd13, 16'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("t4_req_ready", 32'(req_ready), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
    end
    check("t4_ram_reads", 32'(ram_log.size()), 32'd0);
    check("t4_beats", 32'(hs_data.size()), 32'd0);

    // Six beats with out_ready toggling every cycle
    run_req(8'd5, 16'd6, 1'b1);
    check("t5_beats", 32'(hs_data.size()), 32'd6);
    if (hs_data.size() == 6) begin
      check("t5_b0", hs_data[0], 32'hA000_0101);
      check("t5_b3", hs_data[3], 32'hA000_0200);
      check("t5_b5", hs_data[5], 32'hA000_0202);
    end

    // Reset after the second beat of an eight-beat stream
    hs_data.delete();
    for (int i = 0; i < 8; i++) begin
      beat_t bt;
      bt.d = mval(i / 4, i % 4);
      bt.l = (i == 7);
      exp_q.push_back(bt);
    end
    req_valid = 1'b1;
    req_addr  = 8'd0;
    req_count = 16'd8;
    @(posedge clock); #1;
    req_valid = 1'b0;
    guard = 0;
    while (hs_data.size() < 2 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    check("t6_two_beats_seen", 32'(hs_data.size()), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ram_en", 32'(ram_en), 32'd0);

    run_req(8'd13, 16'd2, 1'b0);
    check("t6_new_beats", 32'(hs_data.size()), 32'd2);
    if (hs_data.size() == 2) begin
      check("t6_new_b0", hs_data[0], 32'h11);
      check("t6_new_b1", hs_data[1], 32'h22);
    end

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
